// File: rtl/tug_pkg.sv
// Shared types and helpers for the tug-of-war playfield.
//   field_state_t : playfield FSM states
//   center_idx()  : middle light index (1-based) of an odd-length bar
package tug_pkg;

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    GAP    = 2'd1,
    FROZEN = 2'd2
  } field_state_t;

  function automatic int center_idx(input int n_lights);
    return (n_lights + 1) / 2;
  endfunction

endpackage

// File: rtl/tug_playfield_if.sv
// Playfield signal bundle.
//   key_l/key_r : raw player keys (async to clk)
//   game_over   : freeze level from the scoreboard
//   leds        : bar lights, leds[N_LIGHTS] leftmost
//   press_l/r   : one-cycle synchronized press pulses
//   point_l/r   : one-cycle score pulses
// master = stimulus/upstream side, slave = playfield.
interface tug_playfield_if #(
  parameter int N_LIGHTS = 9
);
  logic                key_l;
  logic                key_r;
  logic                game_over;
  logic [N_LIGHTS:1]   leds;
  logic                press_l;
  logic                press_r;
  logic                point_l;
  logic                point_r;

  modport master (
    output key_l, key_r, game_over,
    input  leds, press_l, press_r, point_l, point_r
  );

  modport slave (
    input  key_l, key_r, game_over,
    output leds, press_l, press_r, point_l, point_r
  );
endinterface

// File: rtl/tug_playfield_key_press.sv
// key_press: two-flop synchronizer followed by rising-edge detect.
//   clk, reset_n : clock, async active-low reset
//   key          : raw asynchronous key level
//   press        : one-cycle pulse per key press (combinational off flops)
module key_press (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic press
);
  logic sync1, sync2, prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Held key gives one pulse: high only the cycle sync2 first reads 1.
  assign press = sync2 & ~prev;
endmodule

// File: rtl/tug_playfield.sv
// tug_playfield: conditions both player keys, walks a single lit LED along
// the bar, and flags a point when a player pushes it off their end.
//   clk, reset_n : clock, async active-low reset
//   pf (slave)   : keys/game_over in; leds, press and point pulses out
// After a point the bar goes dark for GAP_CYCLES cycles, then recenters.
// game_over freezes play (dark bar, no points) until reset.
module tug_playfield
  import tug_pkg::*;
#(
  parameter int N_LIGHTS   = 9,
  parameter int GAP_CYCLES = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  tug_playfield_if.slave  pf
);
  localparam int PW = $clog2(N_LIGHTS + 1);
  localparam int CW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] CENTER   = PW'(center_idx(N_LIGHTS));
  localparam logic [PW-1:0] LAST     = PW'(N_LIGHTS);
  localparam logic [PW-1:0] FIRST    = PW'(1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  // Index 1 = left key, 0 = right key.
  logic [1:0] key_raw, press;
  assign key_raw = {pf.key_l, pf.key_r};

  for (genvar g = 0; g < 2; g++) begin : g_key
    key_press u_kp (
      .clk     (clk),
      .reset_n (reset_n),
      .key     (key_raw[g]),
      .press   (press[g])
    );
  end

  assign pf.press_l = press[1];
  assign pf.press_r = press[0];

  field_state_t  state, state_d;
  logic [PW-1:0] pos, pos_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          pt_l, pt_l_d, pt_r, pt_r_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PLAY;
      pos   <= CENTER;
      cnt   <= '0;
      pt_l  <= 1'b0;
      pt_r  <= 1'b0;
    end else begin
      state <= state_d;
      pos   <= pos_d;
      cnt   <= cnt_d;
      pt_l  <= pt_l_d;
      pt_r  <= pt_r_d;
    end
  end

  always_comb begin
    state_d = state;
    pos_d   = pos;
    cnt_d   = cnt;
    pt_l_d  = 1'b0;
    pt_r_d  = 1'b0;
    // game_over outranks a same-cycle scoring press: no point escapes.
    if (pf.game_over) begin
      state_d = FROZEN;
    end else begin
      case (state)
        PLAY: begin
          if (press[1] && !press[0]) begin
            if (pos == LAST) begin
              pt_l_d  = 1'b1;
              state_d = GAP;
              cnt_d   = '0;
            end else begin
              pos_d = pos + 1'b1;
            end
          end else if (press[0] && !press[1]) begin
            if (pos == FIRST) begin
              pt_r_d  = 1'b1;
              state_d = GAP;
              cnt_d   = '0;
            end else begin
              pos_d = pos - 1'b1;
            end
          end
        end
        GAP: begin
          // Count 0..GAP_CYCLES-1 so the dark window is exactly GAP_CYCLES.
          if (cnt == GAP_LAST) begin
            state_d = PLAY;
            pos_d   = CENTER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
        FROZEN: ;
        default: state_d = PLAY;
      endcase
    end
  end

  assign pf.leds    = (state == PLAY)
                      ? ({{(N_LIGHTS-1){1'b0}}, 1'b1} << (pos - FIRST))
                      : '0;
  assign pf.point_l = pt_l;
  assign pf.point_r = pt_r;
endmodule

// File: tb/tb_tug_playfield.sv
module tb_tug_playfield;
  localparam int N = 9;
  localparam int G = 8;
  localparam int C = (N + 1) / 2;
  localparam logic [8:0] CLED = 9'b000010000;

  logic clk, reset_n;
  tug_playfield_if #(.N_LIGHTS(N)) bus ();

  tug_playfield #(.N_LIGHTS(N), .GAP_CYCLES(G)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pf      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model: game position as an integer, gap as cycles remaining,
  // key presses from the history of levels seen at each clock edge.
  int m_pos, m_gap;
  bit m_frz, m_ptl, m_ptr, m_prl, m_prr;
  bit hl[$], hr[$];

  task automatic model_reset();
    m_pos = C; m_gap = 0; m_frz = 0;
    m_ptl = 0; m_ptr = 0; m_prl = 0; m_prr = 0;
    hl = '{0, 0}; hr = '{0, 0};
  endtask

  task automatic model_edge(input bit kl, input bit kr, input bit go);
    bit pl, pr;
    pl = m_prl; pr = m_prr;
    m_ptl = 0; m_ptr = 0;
    if (m_frz || go) m_frz = 1;
    else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) m_pos = C;
    end else if (pl && !pr) begin
      if (m_pos == N) begin m_ptl = 1; m_gap = G; end
      else m_pos++;
    end else if (pr && !pl) begin
      if (m_pos == 1) begin m_ptr = 1; m_gap = G; end
      else m_pos--;
    end
    // pressed = level seen at the previous edge but not the one before
    m_prl = hl[0] & ~hl[1];
    m_prr = hr[0] & ~hr[1];
    hl.push_front(kl); void'(hl.pop_back());
    hr.push_front(kr); void'(hr.pop_back());
  endtask

  function automatic logic [12:0] mexp();
    logic [8:0] l;
    l = (m_frz || m_gap > 0) ? 9'd0 : (9'd1 << (m_pos - 1));
    return {l, m_prl, m_prr, m_ptl, m_ptr};
  endfunction

  function automatic logic [12:0] act();
    return {bus.leds, bus.press_l, bus.press_r, bus.point_l, bus.point_r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  task automatic cyc(input bit kl, input bit kr, input bit go, input string nm);
    bus.key_l = kl; bus.key_r = kr; bus.game_over = go;
    @(posedge clk); #1;
    model_edge(kl, kr, go);
    chk(nm, 32'(act()), 32'(mexp()));
  endtask

  task automatic press(input bit l, input bit r, input string nm);
    cyc(l, r, 0, nm); cyc(l, r, 0, nm);
    cyc(0, 0, 0, nm); cyc(0, 0, 0, nm);
  endtask

  task automatic do_reset();
    bus.key_l = 0; bus.key_r = 0; bus.game_over = 0;
    reset_n = 0;
    model_reset();
    #2;
    chk("async_reset_leds", 32'(bus.leds), 32'(CLED));
    chk("async_reset_all", 32'(act()), 32'(mexp()));
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  typedef struct packed {
    logic kl, kr, go;
    logic [8:0] leds;
    logic pl, pr, ptl, ptr;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int dark;
    bit rkl, rkr, rgo;
    for (int i = 0; i < 12; i++) begin
      tbl[i].kl = (i < 10); tbl[i].kr = 0; tbl[i].go = 0;
      tbl[i].leds = (i < 2) ? CLED : 9'b000100000;
      tbl[i].pl = (i == 1); tbl[i].pr = 0; tbl[i].ptl = 0; tbl[i].ptr = 0;
    end

    reset_n = 0; bus.key_l = 0; bus.key_r = 0; bus.game_over = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(act()), {19'd0, CLED, 4'b0000});
    reset_n = 1;

    // Hold key_l ten cycles: one pulse, move left two edges after first sample.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].kl, tbl[i].kr, tbl[i].go, "hold_l_model");
      chk($sformatf("hold_l_row%0d", i), 32'(act()),
          32'({tbl[i].leds, tbl[i].pl, tbl[i].pr, tbl[i].ptl, tbl[i].ptr}));
    end

    // Push to the left end, score, dark gap, recenter.
    do_reset();
    repeat (4) press(1, 0, "left_walk");
    chk("left_end", 32'(bus.leds), 32'(9'b100000000));
    cyc(1, 0, 0, "score_l"); cyc(1, 0, 0, "score_l"); cyc(0, 0, 0, "score_l");
    chk("point_l", 32'(bus.point_l), 32'd1);
    dark = (bus.leds == 0) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 0, "gap_l");
      if (bus.leds == 0) dark++;
    end
    cyc(0, 0, 0, "recenter_l");
    chk("gap_len_l", dark, G);
    chk("recenter_l", 32'(bus.leds), 32'(CLED));

    // Right end, simultaneous presses, then right point and presses in GAP.
    do_reset();
    repeat (4) press(0, 1, "right_walk");
    chk("right_end", 32'(bus.leds), 32'd1);
    press(1, 1, "both");
    chk("both_no_move", 32'(bus.leds), 32'd1);
    cyc(0, 1, 0, "score_r"); cyc(0, 1, 0, "score_r"); cyc(0, 0, 0, "score_r");
    chk("point_r", 32'(bus.point_r), 32'd1);
    cyc(1, 1, 0, "gap_both"); cyc(1, 1, 0, "gap_both");
    chk("gap_press_pulses", 32'({bus.press_l, bus.press_r}), 32'b11);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, "gap_r");
    chk("gap_dark_r", 32'({bus.leds, bus.point_l, bus.point_r}), 32'd0);
    cyc(0, 0, 0, "recenter_r");
    chk("recenter_r", 32'(bus.leds), 32'(CLED));

    // game_over in the same cycle as a scoring press.
    do_reset();
    repeat (4) press(1, 0, "left_walk2");
    cyc(1, 0, 0, "go_score"); cyc(1, 0, 0, "go_score");
    chk("go_press_vis", 32'(bus.press_l), 32'd1);
    cyc(1, 0, 1, "go_score");
    chk("go_no_point", 32'({bus.leds, bus.point_l}), 32'd0);
    cyc(0, 0, 1, "frozen"); cyc(0, 1, 1, "frozen"); cyc(0, 1, 1, "frozen");
    chk("frozen_press", 32'({bus.leds, bus.press_r, bus.point_r}), 32'b10);
    cyc(0, 0, 1, "frozen"); cyc(0, 0, 1, "frozen");
    do_reset();
    chk("unfrozen", 32'(bus.leds), 32'(CLED));

    // Asynchronous reset in the middle of a GAP.
    repeat (4) press(1, 0, "left_walk3");
    cyc(1, 0, 0, "score3"); cyc(1, 0, 0, "score3"); cyc(0, 0, 0, "score3");
    cyc(0, 0, 0, "gap3"); cyc(0, 0, 0, "gap3");
    chk("mid_gap_dark", 32'(bus.leds), 32'd0);
    do_reset();

    // Random play, biased so the light reaches both ends.
    rkl = 0; rkr = 0; rgo = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) rkl = ~rkl;
      if ($urandom_range(0, 3) == 0) rkr = ~rkr;
      if (!rgo && $urandom_range(0, 299) == 0) rgo = 1;
      cyc(rkl, rkr, rgo, "random");
      if (rgo && $urandom_range(0, 9) == 0) begin
        do_reset();
        rgo = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/tug_playfield.md
# tug_playfield

Playfield stage of the tug-of-war game: synchronizes and edge-detects the two player keys, moves a single lit LED along an N-light bar, and detects when a player pushes the light off their end. It sits directly upstream of the win-counter/scoreboard stage. It drives the bar LEDs and end-light signals plus one-cycle press pulses. It consumes that stage's game-over level to freeze play.

## Interface
- N_LIGHTS, 9: number of bar lights, odd, ≥3; center index = (N_LIGHTS+1)/2
- GAP_CYCLES, 8: cycles the bar stays dark after a point before recentering, ≥1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- key_l  in  1  raw left-player key level, active-high, asynchronous to clk
- key_r  in  1  raw right-player key level, active-high, asynchronous to clk
- game_over  in  1  level from scoreboard; high = a player has won
- leds  out  [N_LIGHTS:1]  bar lights; leds[N_LIGHTS] is the leftmost light
- press_l  out  1  one-cycle synchronized left press pulse
- press_r  out  1  one-cycle synchronized right press pulse
- point_l  out  1  one-cycle pulse, left player scored
- point_r  out  1  one-cycle pulse, right player scored

## Operation
- Key conditioning per key: two-flop synchronizer, then rising-edge detect (sync2 & ~prev). Holding a key yields exactly one pulse. press_l/press_r are these pulses.
- Position register pos ∈ 1..N_LIGHTS. In PLAY, leds is one-hot at pos. In GAP and FROZEN, leds = 0.
- FSM states:
  - PLAY
    - press_l only: pos<N → pos+1; pos==N → point_l, enter GAP.
    - press_r only: pos>1 → pos−1; pos==1 → point_r, enter GAP.
    - Both presses or neither: no change.
  - GAP: count GAP_CYCLES cycles. When the count expires, pos=center and go to PLAY. Presses ignored.
  - FROZEN: leds=0, no points; press pulses still generated. Exits only via reset.
- game_over high at a clock edge forces FROZEN from any state and takes priority over a same-cycle scoring press, so no point pulse is issued.
- Reset values: state=PLAY, pos=center (leds = one-hot center), sync/prev flops 0, press_*=0, point_*=0, gap counter 0.
- Gap counter width $clog2(GAP_CYCLES+1). The counter never wraps; it clears on GAP entry.

## Timing
- A key sampled high at edge k sets sync2 at edge k+1. The press pulse is high for the cycle following edge k+1. pos/leds update at edge k+2.
- point_l/point_r are registered. They are high for exactly the cycle after the scoring edge, the same cycle leds first reads 0.
- GAP lasts exactly GAP_CYCLES cycles with leds=0. Center lights on the next cycle.
- Reset mid-GAP or mid-FROZEN: immediate return to PLAY/center, asynchronously. Pulses drop at once.
- A key pulse narrower than one clock may be missed. Keys must be held ≥2 cycles.

## Structure
- Shared package tug_pkg: enum field_state_t {PLAY, GAP, FROZEN}, and a center-index function of N_LIGHTS.
- Sub-module key_press (synchronizer + edge detect): instantiated once per key.
- Top holds the FSM, pos register, gap counter, and output decode. Total about 150–250 lines.

## Test plan
- Reset, then release: leds = 9'b000010000, all pulses 0. Hold key_l 10 cycles: exactly one press_l pulse; leds = 9'b000100000 two edges after first sample.
- Four left presses from center: leds[9] lit. Fifth press: point_l one cycle, leds=0 for 8 cycles, then 9'b000010000.
- Four right presses, then key_l and key_r rising in the same cycle: leds stays 9'b000000001 and no point. Next right press gives point_r.
- During GAP, press both keys: press pulses seen, but no point and no movement. Recentering happens on schedule.
- At leds[9], raise game_over in the same cycle as the scoring press pulse: no point_l, leds=0 thereafter. Further presses have no effect until reset_n pulses low, which restores center.
- Assert reset_n low asynchronously mid-GAP: leds = center immediately, without waiting for a clock edge.
